// File: rtl/crom_pixel_serializer.sv
// Sprite C-ROM pixel serializer: latches one burst on LOAD and streams two colour indexes per CLK_EN.
// Define CRS_AUTO_SECOND_HALF_EN to walk both burst halves from a single LOAD.
module crom_pixel_serializer #(
  parameter int unsigned BPP          = 4,
  parameter int unsigned PIX_PER_HALF = 8
) (
  input  logic                          CLK,
  input  logic                          nRESET,
  input  logic                          CLK_EN,
  input  logic                          LOAD,
  input  logic                          CA4,
  input  logic                          H,
  input  logic                          EVEN,
  input  logic [2*PIX_PER_HALF*BPP-1:0] CR_DOUBLE,
  output logic [BPP-1:0]                GAD,
  output logic [BPP-1:0]                GBD,
  output logic                          DOTA,
  output logic                          DOTB,
  output logic                          BUSY
);

  localparam int unsigned HalfW = PIX_PER_HALF * BPP;
  localparam int unsigned Steps = PIX_PER_HALF / 2;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Steps - 1);

  typedef enum logic [1:0] {StIdle, StFirst, StSecond} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               load_q, load_d;
  logic [2*HalfW-1:0] data_q, data_d;
  logic               ca4_q, ca4_d;
  logic               h_q, h_d;
  logic               even_q, even_d;
  logic [BPP-1:0]     gad_q, gad_d;
  logic [BPP-1:0]     gbd_q, gbd_d;
  logic               dota_q, dota_d;
  logic               dotb_q, dotb_d;
  logic               busy_q, busy_d;

  logic               load_evt;
  logic               show;
  logic [2*HalfW-1:0] src_data;
  logic               src_lower;
  logic               src_h;
  logic               src_even;
  logic [HalfW-1:0]   src_half;
  logic [2*BPP-1:0]   pair;

  // Gather bit idx of every bitplane; plane 0 is the colour LSB.
  function automatic logic [BPP-1:0] pix_colour(input logic [HalfW-1:0] half,
                                                input int unsigned     idx);
    logic [BPP-1:0]   c;
    logic [HalfW-1:0] sh;
    c = '0;
    for (int unsigned p = 0; p < BPP; p++) begin
      sh = half >> (p * PIX_PER_HALF + idx);
      c  = c | (BPP'(sh[0]) << p);
    end
    return c;
  endfunction

  // Returns {channel A, channel B} for pair k of one half.
  function automatic logic [2*BPP-1:0] pair_colours(input logic [HalfW-1:0] half,
                                                    input int unsigned     k,
                                                    input logic            hflip,
                                                    input logic            even);
    int unsigned    je;
    int unsigned    jo;
    logic [BPP-1:0] ce;
    logic [BPP-1:0] co;
    je = 2 * k;
    jo = 2 * k + 1;
    if (hflip) begin
      je = PIX_PER_HALF - 1 - je;
      jo = PIX_PER_HALF - 1 - jo;
    end
    ce = pix_colour(half, je);
    co = pix_colour(half, jo);
    return even ? {ce, co} : {co, ce};
  endfunction

  assign load_evt = CLK_EN & LOAD & ~load_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    data_d    = data_q;
    ca4_d     = ca4_q;
    h_d       = h_q;
    even_d    = even_q;
    src_data  = data_q;
    src_lower = ca4_q;
    src_h     = h_q;
    src_even  = even_q;
    show      = 1'b0;
    if (CLK_EN) begin
      load_d = LOAD;
      if (load_evt) begin
        // The new burst is shown at the load edge itself, so select straight from the inputs.
        data_d    = CR_DOUBLE;
        ca4_d     = CA4;
        h_d       = H;
        even_d    = EVEN;
        state_d   = StFirst;
        cnt_d     = '0;
        src_data  = CR_DOUBLE;
        src_lower = CA4;
        src_h     = H;
        src_even  = EVEN;
        show      = 1'b1;
      end else begin
        unique case (state_q)
          StFirst: begin
            if (cnt_q == CntLast) begin
              cnt_d = '0;
`ifdef CRS_AUTO_SECOND_HALF_EN
              state_d   = StSecond;
              src_lower = ~ca4_q;
              show      = 1'b1;
`else
              state_d = StIdle;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
              show  = 1'b1;
            end
          end
          StSecond: begin
            src_lower = ~ca4_q;
            if (cnt_q == CntLast) begin
              cnt_d   = '0;
              state_d = StIdle;
            end else begin
              cnt_d = cnt_q + 1'b1;
              show  = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    src_half = src_lower ? src_data[HalfW-1:0] : src_data[2*HalfW-1:HalfW];
    pair     = pair_colours(src_half, 32'(cnt_d), src_h, src_even);
    gad_d    = gad_q;
    gbd_d    = gbd_q;
    dota_d   = dota_q;
    dotb_d   = dotb_q;
    busy_d   = busy_q;
    if (CLK_EN) begin
      gad_d  = show ? pair[2*BPP-1:BPP] : '0;
      gbd_d  = show ? pair[BPP-1:0] : '0;
      dota_d = |gad_d;
      dotb_d = |gbd_d;
      busy_d = (state_d != StIdle);
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      data_q  <= '0;
      ca4_q   <= 1'b0;
      h_q     <= 1'b0;
      even_q  <= 1'b0;
      gad_q   <= '0;
      gbd_q   <= '0;
      dota_q  <= 1'b0;
      dotb_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      data_q  <= data_d;
      ca4_q   <= ca4_d;
      h_q     <= h_d;
      even_q  <= even_d;
      gad_q   <= gad_d;
      gbd_q   <= gbd_d;
      dota_q  <= dota_d;
      dotb_q  <= dotb_d;
      busy_q  <= busy_d;
    end
  end

  assign GAD  = gad_q;
  assign GBD  = gbd_q;
  assign DOTA = dota_q;
  assign DOTB = dotb_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_crom_pixel_serializer.sv
// Directed bench for crom_pixel_serializer: default geometry plus a BPP=8 / 16-pixel instance.
// Expectations follow CRS_AUTO_SECOND_HALF_EN when it is defined for the build.
module tb_crom_pixel_serializer;

  logic         clk;
  logic         n_reset;
  logic         clk_en;
  logic         load;
  logic         load2;
  logic         ca4;
  logic         h;
  logic         even;
  logic [63:0]  cr;
  logic [255:0] cr2;
  logic [3:0]   gad, gbd;
  logic         dota, dotb, busy;
  logic [7:0]   gad2, gbd2;
  logic         dota2, dotb2, busy2;

  int checks   = 0;
  int failures = 0;

`ifdef CRS_AUTO_SECOND_HALF_EN
  localparam int NP = 8;
  localparam int NW = 16;
  localparam int RP = 5;
`else
  localparam int NP = 4;
  localparam int NW = 8;
  localparam int RP = 2;
`endif
  localparam logic [63:0] C1 = 64'h0123_4567_89AB_CDEF;

  // Hand-decoded pairs of C1: upper half colours F,5,3,0,0,5,3,0; lower F,5,3,F,0,5,3,F.
  logic [3:0] t1a [8];
  logic [3:0] t1b [8];
  logic [3:0] t2a [8];
  logic [3:0] t2b [8];

  crom_pixel_serializer #(
    .BPP          (4),
    .PIX_PER_HALF (8)
  ) u_dut (
    .CLK       (clk),
    .nRESET    (n_reset),
    .CLK_EN    (clk_en),
    .LOAD      (load),
    .CA4       (ca4),
    .H         (h),
    .EVEN      (even),
    .CR_DOUBLE (cr),
    .GAD       (gad),
    .GBD       (gbd),
    .DOTA      (dota),
    .DOTB      (dotb),
    .BUSY      (busy)
  );

  crom_pixel_serializer #(
    .BPP          (8),
    .PIX_PER_HALF (16)
  ) u_dut_wide (
    .CLK       (clk),
    .nRESET    (n_reset),
    .CLK_EN    (clk_en),
    .LOAD      (load2),
    .CA4       (ca4),
    .H         (h),
    .EVEN      (even),
    .CR_DOUBLE (cr2),
    .GAD       (gad2),
    .GBD       (gbd2),
    .DOTA      (dota2),
    .DOTB      (dotb2),
    .BUSY      (busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    clk_en  = 1'b1;
    load    = 1'b0;
    load2   = 1'b0;
    ca4     = 1'b0;
    h       = 1'b0;
    even    = 1'b1;
    cr      = '0;
    cr2     = '0;
    step();
    step();
    checks++;
    if (gad !== 4'h0 || gbd !== 4'h0 || dota !== 1'b0 || dotb !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got GAD=%h GBD=%h DOTA=%b DOTB=%b BUSY=%b, want all 0",
               gad, gbd, dota, dotb, busy);
    end
    n_reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || gad !== 4'h0 || busy2 !== 1'b0 || gad2 !== 8'h00) begin
      failures++;
      $display("FAIL reset_release_idle: got BUSY=%b GAD=%h BUSY2=%b GAD2=%h, want 0 0 0 0",
               busy, gad, busy2, gad2);
    end
  endtask

  task automatic test_main();
    logic [3:0] ea, eb;
    logic       eby;
    load = 1'b0;
    step();
    cr   = C1;
    ca4  = 1'b0;
    h    = 1'b0;
    even = 1'b1;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      ea  = (i < NP) ? t1a[i % 8] : 4'h0;
      eb  = (i < NP) ? t1b[i % 8] : 4'h0;
      eby = (i < NP);
      checks++;
      if (gad !== ea || gbd !== eb || dota !== (ea != 0) || dotb !== (eb != 0) || busy !== eby)
      begin
        failures++;
        $display("FAIL main_pair%0d: got GAD=%h GBD=%h DOTA=%b DOTB=%b BUSY=%b, want %h %h %b %b %b",
                 i, gad, gbd, dota, dotb, busy, ea, eb, ea != 0, eb != 0, eby);
      end
    end
  endtask

  task automatic test_flip_swap();
    logic [3:0] ea, eb;
    logic       eby;
    load = 1'b0;
    step();
    cr   = C1;
    ca4  = 1'b0;
    h    = 1'b1;
    even = 1'b0;
    load = 1'b1;
    step();
    load = 1'b0;
    h    = 1'b0;
    even = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      ea  = (i < NP) ? t2a[i % 8] : 4'h0;
      eb  = (i < NP) ? t2b[i % 8] : 4'h0;
      eby = (i < NP);
      checks++;
      if (gad !== ea || gbd !== eb || dota !== (ea != 0) || dotb !== (eb != 0) || busy !== eby)
      begin
        failures++;
        $display("FAIL flip_pair%0d: got GAD=%h GBD=%h DOTA=%b DOTB=%b BUSY=%b, want %h %h %b %b %b",
                 i, gad, gbd, dota, dotb, busy, ea, eb, ea != 0, eb != 0, eby);
      end
    end
  endtask

  task automatic test_reload();
    logic [3:0] ex;
    logic       eby;
    load = 1'b0;
    step();
    cr   = C1;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    checks++;
    if (gad !== t1a[2] || gbd !== t1b[2]) begin
      failures++;
      $display("FAIL reload_pre: got GAD=%h GBD=%h, want %h %h", gad, gbd, t1a[2], t1b[2]);
    end
    cr   = 64'hFFFF_FFFF_FFFF_FFFF;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      ex  = (i < NP) ? 4'hF : 4'h0;
      eby = (i < NP);
      checks++;
      if (gad !== ex || gbd !== ex || busy !== eby) begin
        failures++;
        $display("FAIL reload_pair%0d: got GAD=%h GBD=%h BUSY=%b, want %h %h %b",
                 i, gad, gbd, busy, ex, ex, eby);
      end
    end
  endtask

  task automatic test_gate();
    logic [3:0] ea, eb;
    logic       eby;
    load = 1'b0;
    step();
    cr   = C1;
    load = 1'b1;
    step();
    checks++;
    if (gad !== t1a[0] || gbd !== t1b[0] || busy !== 1'b1) begin
      failures++;
      $display("FAIL gate_pair0: got GAD=%h GBD=%h BUSY=%b, want %h %h 1",
               gad, gbd, busy, t1a[0], t1b[0]);
    end
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (gad !== t1a[0] || gbd !== t1b[0] || busy !== 1'b1) begin
        failures++;
        $display("FAIL gate_hold%0d: got GAD=%h GBD=%h BUSY=%b, want %h %h 1",
                 i, gad, gbd, busy, t1a[0], t1b[0]);
      end
    end
    clk_en = 1'b1;
    for (int i = 1; i < 9; i++) begin
      step();
      if (i == 2) load = 1'b0;
      ea  = (i < NP) ? t1a[i % 8] : 4'h0;
      eb  = (i < NP) ? t1b[i % 8] : 4'h0;
      eby = (i < NP);
      checks++;
      if (gad !== ea || gbd !== eb || busy !== eby) begin
        failures++;
        $display("FAIL gate_pair%0d: got GAD=%h GBD=%h BUSY=%b, want %h %h %b",
                 i, gad, gbd, busy, ea, eb, eby);
      end
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b0;
    step();
    cr   = C1;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (RP) step();
    checks++;
    if (gad !== t1a[RP] || gbd !== t1b[RP] || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: got GAD=%h GBD=%h BUSY=%b, want %h %h 1",
               gad, gbd, busy, t1a[RP], t1b[RP]);
    end
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if (gad !== 4'h0 || gbd !== 4'h0 || dota !== 1'b0 || dotb !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got GAD=%h GBD=%h DOTA=%b DOTB=%b BUSY=%b, want all 0",
               gad, gbd, dota, dotb, busy);
    end
    #2;
    n_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (gad !== 4'h0 || gbd !== 4'h0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_idle%0d: got GAD=%h GBD=%h BUSY=%b, want 0 0 0", i, gad, gbd, busy);
      end
    end
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (gad !== t1a[0] || gbd !== t1b[0] || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_newload: got GAD=%h GBD=%h BUSY=%b, want %h %h 1",
               gad, gbd, busy, t1a[0], t1b[0]);
    end
    repeat (10) step();
  endtask

  task automatic test_wide();
    logic [7:0] ex;
    logic       eby;
    load2 = 1'b0;
    step();
    cr2   = {{128{1'b1}}, 128'h0};
    ca4   = 1'b0;
    h     = 1'b0;
    even  = 1'b1;
    load2 = 1'b1;
    step();
    load2 = 1'b0;
    for (int i = 0; i <= NW; i++) begin
      if (i > 0) step();
      ex  = (i < 8) ? 8'hFF : 8'h00;
      eby = (i < NW);
      checks++;
      if (gad2 !== ex || gbd2 !== ex || dota2 !== (ex != 0) || busy2 !== eby) begin
        failures++;
        $display("FAIL wide_upper%0d: got GAD=%h GBD=%h DOTA=%b BUSY=%b, want %h %h %b %b",
                 i, gad2, gbd2, dota2, busy2, ex, ex, ex != 0, eby);
      end
    end
    step();
    ca4   = 1'b1;
    load2 = 1'b1;
    step();
    load2 = 1'b0;
    ca4   = 1'b0;
    for (int i = 0; i <= NW; i++) begin
      if (i > 0) step();
      ex  = (i >= 8 && i < NW) ? 8'hFF : 8'h00;
      eby = (i < NW);
      checks++;
      if (gad2 !== ex || gbd2 !== ex || dotb2 !== (ex != 0) || busy2 !== eby) begin
        failures++;
        $display("FAIL wide_lower%0d: got GAD=%h GBD=%h DOTB=%b BUSY=%b, want %h %h %b %b",
                 i, gad2, gbd2, dotb2, busy2, ex, ex, ex != 0, eby);
      end
    end
  endtask

  initial begin
    t1a = '{4'hF, 4'h3, 4'h0, 4'h3, 4'hF, 4'h3, 4'h0, 4'h3};
    t1b = '{4'h5, 4'h0, 4'h5, 4'h0, 4'h5, 4'hF, 4'h5, 4'hF};
    t2a = '{4'h3, 4'h0, 4'h3, 4'hF, 4'h3, 4'h0, 4'h3, 4'hF};
    t2b = '{4'h0, 4'h5, 4'h0, 4'h5, 4'hF, 4'h5, 4'hF, 4'h5};
    test_reset();
    test_main();
    test_flip_swap();
    test_reload();
    test_gate();
    test_reset_mid();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crom_pixel_serializer.md
# crom_pixel_serializer

Parametrised sprite-graphics pixel serializer, successor to the fixed 4bpp/8-pixel NEO-ZMC2 path. It latches one 16-pixel C-ROM burst (CR_DOUBLE) on LOAD and streams colour indexes two pixels per pixel-enable on channels A and B, toward the B1 line-buffer writer. It adds generic bit depth and tile width, and automatic sequencing of both burst halves from a single LOAD. H-flip and EVEN swap are resolved internally.

## Interface
Parameters:
- BPP, 4, bits per pixel (bitplanes per half); 1..8
- PIX_PER_HALF, 8, pixels per burst half; even, 2..16

Ports:
- CLK  in  1  system clock (48 MHz domain)
- nRESET  in  1  asynchronous, active-low reset
- CLK_EN  in  1  pixel-pair enable (12 MHz rate); all state advances only on CLK edges with CLK_EN=1
- LOAD  in  1  tile load strobe; rising edge sampled under CLK_EN
- CA4  in  1  first-half select: 0 = upper half first, 1 = lower half first
- H  in  1  horizontal flip, sampled at load
- EVEN  in  1  1 = channel A gets even pixel index, 0 = swapped; sampled at load
- CR_DOUBLE  in  2*PIX_PER_HALF*BPP  burst data: {upper half, lower half}; within a half, plane p occupies bits [p*PIX_PER_HALF +: PIX_PER_HALF], bit i = pixel i
- GAD  out  BPP  channel A colour index
- GBD  out  BPP  channel B colour index
- DOTA  out  1  GAD != 0
- DOTB  out  1  GBD != 0
- BUSY  out  1  high while not IDLE

## Operation
- States: IDLE, FIRST, SECOND. Pair counter cnt, width clog2(PIX_PER_HALF/2), STEPS = PIX_PER_HALF/2.
- Load event: CLK_EN=1 and LOAD=1 and LOAD_d=0 (LOAD_d updated on every CLK_EN edge; reset 0).
- On load: latch full CR_DOUBLE, CA4, H, EVEN; cnt<=0; state<=FIRST; output pair 0 of the first half at this same edge.
- Pixel index for pair k: e=2k, o=2k+1; if H=1, index j maps to PIX_PER_HALF-1-j. Colour = {plane BPP-1[j], ..., plane0[j]}.
- EVEN=1: GAD=colour(e), GBD=colour(o); EVEN=0: swapped.
- Each further CLK_EN edge: cnt++ and output next pair. When cnt=STEPS-1 in FIRST: next edge -> SECOND, cnt=0, pair 0 of other half. When cnt=STEPS-1 in SECOND: next edge -> IDLE, GAD=GBD=0.
- Load event in any state (including mid-half) aborts the current tile and restarts at FIRST with the new data; no pending queue.
- IDLE: outputs held 0.
- CLK_EN=0: all registers hold.

## Timing
- Reset values: GAD=0, GBD=0, DOTA=0, DOTB=0, BUSY=0, state IDLE, cnt=0, LOAD_d=0.
- All outputs registered; DOTA/DOTB derived from the same edge as GAD/GBD (no extra cycle).
- Latency: pair 0 visible after the load edge; one tile = 2*STEPS CLK_EN edges of output; BUSY falls on edge 2*STEPS after load.
- LOAD held high does not retrigger; must drop for at least one CLK_EN edge.
- Reset asserted mid-tile: immediate return to reset values, latched data discarded.

## Configuration
- CRS_AUTO_SECOND_HALF_EN defined: FIRST -> SECOND sequencing as above, one LOAD per 16-pixel tile.
- Not defined: after FIRST completes, state -> IDLE and outputs 0. SECOND is never entered. Each half needs its own LOAD with CA4 selecting the half, which is legacy ZMC2 behaviour. BUSY falls after STEPS edges.

## Test plan
- Default params, macro on: CR_DOUBLE=64'h0123456789ABCDEF, CA4=0, H=0, EVEN=1, one LOAD. Expect 8 pairs matching the plane-decoded model, upper half then lower half. Expect BUSY high for exactly 8 CLK_EN edges, then GAD=GBD=0.
- Same data, H=1 and EVEN=0. Expect pixel order reversed per half and channels swapped. Expect DOTA/DOTB low exactly where the colour is 0.
- Mid-tile reload: second LOAD with CR_DOUBLE=64'hFFFF_FFFF_FFFF_FFFF at pair 2 of FIRST. Next output is GAD=GBD=4'hF and the counter restarts; BUSY lasts 8 more edges.
- CLK_EN gated low for 5 CLK cycles mid-stream, with LOAD held high for 3 enables. Outputs freeze during the gap and resume at the next pair. Only one load is registered.
- nRESET pulsed low at pair 5. All outputs 0 asynchronously; after release, the module stays IDLE until a new LOAD.
- BPP=8, PIX_PER_HALF=16, macro off. Load all-ones in the upper half only, CA4=0. Expect 8 pairs of 8'hFF, then IDLE with no second half.
